// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment display arbiter:
// segment patterns, special digit codes, requester indices, FSM state type.
package display_pkg;

  typedef enum logic {IDLE, OWNED} arb_state_e;

  localparam int NUM_REQ    = 3;
  localparam int REQ_ALERT  = 2;
  localparam int REQ_SET    = 1;
  localparam int REQ_MAIN   = 0;

  localparam logic [3:0] CODE_S     = 4'd10;
  localparam logic [3:0] CODE_T     = 4'd11;
  localparam logic [3:0] CODE_E     = 4'd12;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_T     = 7'b0000111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Fixed priority: alert > set-mode > main.
  function automatic logic [NUM_REQ-1:0] prio_onehot(input logic [NUM_REQ-1:0] r);
    logic [NUM_REQ-1:0] g;
    g = '0;
    if (r[REQ_ALERT])     g[REQ_ALERT] = 1'b1;
    else if (r[REQ_SET])  g[REQ_SET]   = 1'b1;
    else if (r[REQ_MAIN]) g[REQ_MAIN]  = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit digit code to active-low 7-segment pattern.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    case (code)
      4'd0:   seg_n = SEG_0;
      4'd1:   seg_n = SEG_1;
      4'd2:   seg_n = SEG_2;
      4'd3:   seg_n = SEG_3;
      4'd4:   seg_n = SEG_4;
      4'd5:   seg_n = SEG_5;
      4'd6:   seg_n = SEG_6;
      4'd7:   seg_n = SEG_7;
      4'd8:   seg_n = SEG_8;
      4'd9:   seg_n = SEG_9;
      CODE_S: seg_n = SEG_S;
      CODE_T: seg_n = SEG_T;
      CODE_E: seg_n = SEG_E;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_arbiter.sv
// Frame-synchronous arbiter sharing an 8-digit multiplexed 7-segment display
// among three requesters; ownership only changes on frame boundaries.
module display_arbiter
  import display_pkg::*;
#(
  parameter int SCAN_BITS    = 16,
  parameter int DEAD_CYCLES  = 16,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  req,
  input  logic [31:0] digits0,
  input  logic [31:0] digits1,
  input  logic [31:0] digits2,
  input  logic [7:0]  blank0,
  input  logic [7:0]  blank1,
  input  logic [7:0]  blank2,
  input  logic [7:0]  blink0,
  input  logic [7:0]  blink1,
  input  logic [7:0]  blink2,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic [2:0]  gnt,
  output logic        frame_tick
);

  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [SCAN_BITS-1:0] cnt_q, cnt_nxt;
  logic [2:0]           dig_q, dig_nxt;
  arb_state_e           state_q, state_nxt;
  logic [2:0]           gnt_q, gnt_nxt;
  logic                 phase_q, phase_nxt;
  logic [BW-1:0]        bcnt_q, bcnt_nxt;
  logic [3:0]           code_q, code_nxt;
  logic [6:0]           seg_q, seg_nxt, dec_seg;
  logic [7:0]           an_q, an_nxt;
  logic [31:0]          own_digits;
  logic [7:0]           own_blank, own_blink;
  logic                 in_dead;

  // Scan timing runs regardless of ownership.
  assign cnt_nxt    = cnt_q + 1'b1;
  assign dig_nxt    = dig_q + {2'b00, &cnt_q};
  assign frame_tick = (&cnt_q) && (dig_q == 3'd7);

  // FSM: ownership is only re-evaluated on the frame boundary.
  always_comb begin
    state_nxt = state_q;
    gnt_nxt   = gnt_q;
    if (frame_tick) begin
      if (|req) begin
        state_nxt = OWNED;
        gnt_nxt   = prio_onehot(req);
      end else begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    end
  end

  always_comb begin
    phase_nxt = phase_q;
    bcnt_nxt  = bcnt_q;
    if (frame_tick) begin
      if (gnt_nxt != gnt_q) begin
        phase_nxt = 1'b0;
        bcnt_nxt  = '0;
      end else if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
        phase_nxt = ~phase_q;
        bcnt_nxt  = '0;
      end else begin
        bcnt_nxt  = bcnt_q + 1'b1;
      end
    end
  end

  // Owner data mux, steered by the grant that will be in force next cycle.
  always_comb begin
    own_digits = '0;
    own_blank  = '0;
    own_blink  = '0;
    if (gnt_nxt[REQ_ALERT]) begin
      own_digits = digits2; own_blank = blank2; own_blink = blink2;
    end else if (gnt_nxt[REQ_SET]) begin
      own_digits = digits1; own_blank = blank1; own_blink = blink1;
    end else if (gnt_nxt[REQ_MAIN]) begin
      own_digits = digits0; own_blank = blank0; own_blink = blink0;
    end
  end

  // Code is latched as the slot begins and held for the whole slot.
  assign code_nxt = (cnt_nxt == '0) ? own_digits[{dig_nxt, 2'b00} +: 4] : code_q;

  seg7_decode u_dec (
    .code  (code_nxt),
    .seg_n (dec_seg)
  );

  generate
    if (DEAD_CYCLES == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      localparam logic [SCAN_BITS-1:0] DEAD = SCAN_BITS'(DEAD_CYCLES);
      assign in_dead = (cnt_nxt < DEAD);
    end
  endgenerate

  // Outputs are computed from next-cycle scan state so seg/an line up with
  // the counter and switch on the same edge.
  always_comb begin
    an_nxt  = 8'hFF;
    seg_nxt = SEG_BLANK;
    if (state_nxt == OWNED) begin
      if (!in_dead) an_nxt[dig_nxt] = 1'b0;
      if (!own_blank[dig_nxt] && !(own_blink[dig_nxt] && phase_nxt))
        seg_nxt = dec_seg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      dig_q   <= '0;
      state_q <= IDLE;
      gnt_q   <= '0;
      phase_q <= 1'b0;
      bcnt_q  <= '0;
      code_q  <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= 8'hFF;
    end else begin
      cnt_q   <= cnt_nxt;
      dig_q   <= dig_nxt;
      state_q <= state_nxt;
      gnt_q   <= gnt_nxt;
      phase_q <= phase_nxt;
      bcnt_q  <= bcnt_nxt;
      code_q  <= code_nxt;
      seg_q   <= seg_nxt;
      an_q    <= an_nxt;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign gnt = gnt_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: directed frame-level vectors,
// corner-case sequences and random stimulus against a cycle-count model.
module tb_display_arbiter;
  localparam int SB = 4, DC = 2, BF = 2;
  localparam int SLOT = 1 << SB, FRAME = 8 * SLOT;

  logic        clk = 1'b0, reset_n;
  logic [2:0]  req;
  logic [31:0] digits0, digits1, digits2;
  logic [7:0]  blank0, blank1, blank2, blink0, blink1, blink2;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic [2:0]  gnt;
  logic        frame_tick;

  always #5 clk = ~clk;

  display_arbiter #(.SCAN_BITS(SB), .DEAD_CYCLES(DC), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .digits0(digits0), .digits1(digits1), .digits2(digits2),
    .blank0(blank0), .blank1(blank1), .blank2(blank2),
    .blink0(blink0), .blink1(blink1), .blink2(blink2),
    .seg(seg), .an(an), .gnt(gnt), .frame_tick(frame_tick)
  );

  int tot = 0, pas = 0;
  // model: cycles since reset release, owner, frames since owner change, latched code
  int mn, mfs;
  logic [2:0] mg;
  logic [3:0] mcode;
  logic [6:0] dec_tab [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act === exp) pas++;
    else $display("FAIL %s: got %h expected %h (model cycle %0d)", nm, act, exp, mn);
  endtask

  function automatic logic [2:0] pick(input logic [2:0] r);
    if (r[2]) return 3'b100;
    if (r[1]) return 3'b010;
    if (r[0]) return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic [31:0] own_dig();
    case (mg)
      3'b100: return digits2;
      3'b010: return digits1;
      3'b001: return digits0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [15:0] own_masks(); // {blink, blank}
    case (mg)
      3'b100: return {blink2, blank2};
      3'b010: return {blink1, blank1};
      3'b001: return {blink0, blank0};
      default: return 16'h0;
    endcase
  endfunction

  task automatic model_reset();
    mn = 0; mfs = 0; mg = 3'b000; mcode = 4'h0;
  endtask

  task automatic model_step();
    logic [2:0] ng;
    if ((mn % FRAME) == FRAME - 1) begin
      ng = pick(req);
      if (ng != mg) mfs = 0; else mfs++;
      mg = ng;
    end
    mn++;
    if ((mn % SLOT) == 0) mcode = 4'(own_dig() >> (4 * ((mn / SLOT) % 8)));
  endtask

  task automatic compare_all();
    int c, d;
    logic [15:0] m;
    logic [7:0] ea;
    logic [6:0] es;
    logic ph;
    c = mn % SLOT; d = (mn / SLOT) % 8;
    m = own_masks();
    ph = ((mfs / BF) % 2) == 1;
    ea = (mg == 0 || c < DC) ? 8'hFF : ~(8'h01 << d);
    es = (mg == 0 || m[d] || (m[8+d] && ph)) ? 7'h7F : dec_tab[mcode];
    chk("an", an, ea);
    chk("seg", seg, es);
    chk("gnt", gnt, mg);
    chk("frame_tick", frame_tick, 32'((c == SLOT - 1) && (d == 7)));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_to(input int pos);
    int k;
    k = 0;
    while ((mn % FRAME) != pos && k < 2 * FRAME) begin tick(); k++; end
    if ((mn % FRAME) != pos) chk("run_to_bound", mn % FRAME, pos);
  endtask

  task automatic grant_latency(input string nm);
    int k;
    k = 0;
    do begin tick(); k++; end while (gnt == 3'b000 && k < 3 * FRAME);
    chk(nm, k, FRAME);
  endtask

  task automatic reset_outs(input string nm);
    chk({nm, "_seg"}, seg, 7'h7F);
    chk({nm, "_an"}, an, 8'hFF);
    chk({nm, "_gnt"}, gnt, 3'b000);
    chk({nm, "_ft"}, frame_tick, 1'b0);
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [31:0] d0, d1, d2;
    logic [7:0]  bl0;
    logic [2:0]  e_gnt;
    logic [6:0]  e_seg;
    logic [7:0]  e_an;
  } vec_t;
  vec_t vt [8];

  initial begin
    dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h12, 7'h07, 7'h06, 7'h7F, 7'h7F, 7'h7F};
    // digit-0 slot, scan cycle 5, in the frame after the inputs were applied
    vt[0] = '{3'b001, 32'h3, 32'h0, 32'h0, 8'h00, 3'b001, 7'h30, 8'hFE};
    vt[1] = '{3'b111, 32'h0, 32'h0, 32'hA, 8'h00, 3'b100, 7'h12, 8'hFE};
    vt[2] = '{3'b010, 32'h0, 32'hB, 32'h1, 8'h00, 3'b010, 7'h07, 8'hFE};
    vt[3] = '{3'b011, 32'h8, 32'hC, 32'h0, 8'h00, 3'b010, 7'h06, 8'hFE};
    vt[4] = '{3'b001, 32'hD, 32'h0, 32'h0, 8'h00, 3'b001, 7'h7F, 8'hFE};
    vt[5] = '{3'b001, 32'h6, 32'h0, 32'h0, 8'h01, 3'b001, 7'h7F, 8'hFE};
    vt[6] = '{3'b001, 32'h7, 32'h0, 32'h0, 8'h02, 3'b001, 7'h78, 8'hFE};
    vt[7] = '{3'b000, 32'h1, 32'h0, 32'h0, 8'h00, 3'b000, 7'h7F, 8'hFF};

    reset_n = 1'b0; req = 3'b001;
    digits0 = 32'h0000_0059; digits1 = '0; digits2 = '0;
    blank0 = '0; blank1 = '0; blank2 = '0; blink0 = '0; blink1 = '0; blink2 = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_outs("reset");
    reset_n = 1'b1;

    // first grant and first digits after release
    grant_latency("first_grant_cycles");
    chk("first_gnt", gnt, 3'b001);
    run_to(1);  chk("dead_an_c1", an, 8'hFF);
    run_to(2);  chk("d0_an", an, 8'hFE); chk("d0_seg9", seg, 7'b0010000);
    run_to(18); chk("d1_an", an, 8'hFD); chk("d1_seg5", seg, 7'b0010010);

    foreach (vt[i]) begin
      req = vt[i].req; digits0 = vt[i].d0; digits1 = vt[i].d1; digits2 = vt[i].d2;
      blank0 = vt[i].bl0;
      run_to(FRAME - 1); tick(); run_to(5);
      chk($sformatf("vec%0d_gnt", i), gnt, vt[i].e_gnt);
      chk($sformatf("vec%0d_seg", i), seg, vt[i].e_seg);
      chk($sformatf("vec%0d_an", i), an, vt[i].e_an);
    end
    blank0 = '0;

    // higher priority arriving mid-frame waits for frame_tick
    req = 3'b001; digits0 = 32'h0;
    run_to(FRAME - 1); tick();
    run_to(40); req = 3'b101;
    run_to(FRAME - 1);
    chk("preempt_hold", gnt, 3'b001); chk("preempt_ft", frame_tick, 1'b1);
    tick(); chk("preempt_gnt", gnt, 3'b100);

    // owner drops mid-frame with no other request
    req = 3'b001;
    run_to(FRAME - 1); tick();
    run_to(60); req = 3'b000;
    run_to(FRAME - 1); chk("drop_hold", gnt, 3'b001);
    tick(); chk("drop_idle", gnt, 3'b000);
    run_to(20); chk("idle_an", an, 8'hFF); chk("idle_seg", seg, 7'h7F);

    // blink: 2 frames E, 2 frames blank on digits 0-1; digit 2 steady
    req = 3'b010; digits1 = 32'h0000_03CC; blink1 = 8'h03;
    run_to(FRAME - 1); tick();
    for (int f = 0; f < 6; f++) begin
      run_to(5);  chk($sformatf("blink_f%0d_d0", f), seg, (f % 4 < 2) ? 7'h06 : 7'h7F);
      run_to(21); chk($sformatf("blink_f%0d_d1", f), seg, (f % 4 < 2) ? 7'h06 : 7'h7F);
      run_to(37); chk($sformatf("blink_f%0d_d2", f), seg, 7'h30);
      run_to(FRAME - 1); tick();
    end

    // async reset at digit 5 of an owned frame
    run_to(5 * SLOT + 7);
    reset_n = 1'b0;
    #1;
    reset_outs("midreset");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_outs("midreset_hold");
    reset_n = 1'b1;
    grant_latency("regrant_cycles");
    chk("regrant_gnt", gnt, 3'b010);

    // all requesters at a frame boundary
    req = 3'b111; blink1 = 8'h00;
    run_to(FRAME - 1); tick();
    chk("all_req_gnt", gnt, 3'b100);
    for (int k = 0; k < FRAME; k++) begin
      tick();
      if ((mn % SLOT) < DC) chk("all_req_dead_an", an, 8'hFF);
    end

    // random traffic against the model
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 99) < 2) req = 3'($urandom);
      if ($urandom_range(0, 99) < 5) begin
        digits0 = $urandom; digits1 = $urandom; digits2 = $urandom;
      end
      if ($urandom_range(0, 99) < 3) begin
        blank0 = 8'($urandom) & 8'($urandom); blank1 = 8'($urandom) & 8'($urandom);
        blank2 = 8'($urandom) & 8'($urandom);
        blink0 = 8'($urandom); blink1 = 8'($urandom); blink2 = 8'($urandom);
      end
      tick();
    end

    $display("%0d/%0d checks passed", pas, tot);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter SCAN_BITS, default 16; digit slot length = 2^SCAN_BITS clk cycles.
REQ-002 Parameter DEAD_CYCLES, default 16; anode-off guard at the start of each slot; legal range 0 to 2^SCAN_BITS-1.
REQ-003 Parameter BLINK_FRAMES, default 32; frames per blink half-period.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  3  display requests; index 2 = alert, 1 = set-mode, 0 = main.
REQ-007 digits0, digits1, digits2  input  32 each  eight 4-bit digit codes; nibble k feeds digit k.
REQ-008 blank0, blank1, blank2  input  8 each  per-digit force-blank mask.
REQ-009 blink0, blink1, blink2  input  8 each  per-digit blink-enable mask.
REQ-010 seg  output  7  active-low segments {g,f,e,d,c,b,a}; registered.
REQ-011 an  output  8  active-low anodes; bit k = digit k; registered.
REQ-012 gnt  output  3  one-hot current display owner, or all zero; registered.
REQ-013 frame_tick  output  1  one-cycle pulse at the end of each 8-digit frame.

Function
REQ-014 A free-running scan counter of SCAN_BITS bits and a 3-bit digit index SHALL advance continuously, independent of grant state; the digit index increments when the scan counter wraps, 7 wraps to 0.
REQ-015 frame_tick SHALL be high for exactly the one cycle in which the scan counter is all ones and the digit index is 7.
REQ-016 FSM states: IDLE (gnt=0) and OWNED (gnt one-hot).
REQ-017 Grant re-evaluation SHALL occur only in frame_tick cycles; the new gnt takes effect on the following cycle, aligned with the start of digit 0.
REQ-018 At re-evaluation, gnt SHALL become the highest-priority asserted req bit (2 > 1 > 0); if no req bit is asserted, the FSM goes to IDLE.
REQ-019 The current owner dropping req mid-frame SHALL NOT change gnt before the next frame_tick; its live data continues to be displayed.
REQ-020 A higher-priority req arriving mid-frame SHALL be granted at the next frame_tick; worst-case request-to-grant latency is 8*2^SCAN_BITS cycles.
REQ-021 In IDLE, an SHALL be 8'hFF and seg SHALL be 7'h7F.
REQ-022 In OWNED, an SHALL be 8'hFF while the scan counter is < DEAD_CYCLES, and otherwise only bit [digit index] SHALL be low.
REQ-023 The displayed code SHALL be the owner's nibble [digit index], sampled when the scan counter is 0 and held for the whole slot.
REQ-024 A digit SHALL show blank (7'h7F) when the owner's blank bit is set, or when its blink bit is set and the blink phase is 1.
REQ-025 The blink phase SHALL toggle every BLINK_FRAMES frame_ticks, and SHALL reset to 0 whenever gnt changes.
REQ-026 Decode: 0-9 standard digits; 10 = S (7'b0010010); 11 = t (7'b0000111); 12 = E (7'b0000110); 13-15 = blank.
REQ-027 seg and an SHALL change together on the same clock edge, so there is no ghosting skew.

Reset
REQ-028 While reset_n = 0: seg = 7'h7F, an = 8'hFF, gnt = 0, frame_tick = 0, FSM = IDLE, scan counter = 0, digit index = 0, blink phase = 0.
REQ-029 Reset asserted mid-frame SHALL force these values immediately; after release the first grant occurs at the first frame_tick.

Structure
REQ-030 The shared package display_pkg SHALL hold the 7-segment decode constants and the digit-code constants (S, t, E, BLANK), together with the requester index constants.
REQ-031 The single sub-module seg7_decode SHALL be purely combinational: 4-bit code in, 7-bit active-low segments out.

Verification (SCAN_BITS=4, DEAD_CYCLES=2, BLINK_FRAMES=2)
REQ-032 Release reset with req=3'b001 and digits0=32'h0000_0059 -> gnt=001 in the cycle after the first frame_tick; the digit-0 slot shows 7'b0010000 (9) on an=8'hFE from slot cycle 2; the digit-1 slot shows 7'b0010010 (5).
REQ-033 With req0 owning, assert req2 at cycle 40 of a frame -> gnt stays 001 until frame_tick, then becomes 100 on the next cycle.
REQ-034 Owner 0 drops req mid-frame with no other requests -> gnt=001 until frame_tick, then IDLE with an=8'hFF and seg=7'h7F.
REQ-035 Owner 1 with blink1=8'h03 and digits1 nibbles 0,1 = 12 -> digits 0-1 show E for 2 frames, then blank for 2 frames, repeating; digits 2-7 unaffected.
REQ-036 Pulse reset_n low at digit 5 of an owned frame -> outputs immediately match REQ-028; the next grant occurs 128 cycles after release.
REQ-037 req=3'b111 at a frame boundary -> gnt=100, and no anode is ever low during slot cycles 0-1.
